load_store_unit: RTL and testbench

//  Memory stage directly downstream of the ALU. Takes ALUResult as the effective address, plus rs2 as store data.

---
 rtl/load_store_unit.sv | 163 ++++++++++++++++
 tb/tb_load_store_unit.sv | 194 +++++++++++++++++++
 2 files changed

// File: rtl/load_store_unit.sv
// Memory stage after the ALU: sequences one load/store over a req/ack data port,
// steers store byte lanes, extracts/extends load data, and flags misalignment and timeouts.
module load_store_unit #(
   parameter int unsigned DATA_WIDTH     = 32,
   parameter int unsigned TIMEOUT_CYCLES = 16
) (
   input  logic                    clk,
   input  logic                    rst_n,
   input  logic                    req_valid,
   output logic                    req_ready,
   input  logic                    req_load,
   input  logic                    req_store,
   input  logic [1:0]              req_size,
   input  logic                    req_unsigned,
   input  logic [31:0]             addr,
   input  logic [DATA_WIDTH-1:0]   wdata,
   input  logic [4:0]              rd_addr,
   output logic                    stall,
   output logic                    mem_req,
   output logic                    mem_we,
   output logic [31:0]             mem_addr,
   output logic [3:0]              mem_wstrb,
   output logic [DATA_WIDTH-1:0]   mem_wdata,
   input  logic                    mem_ack,
   input  logic [DATA_WIDTH-1:0]   mem_rdata,
   output logic                    resp_valid,
   output logic [DATA_WIDTH-1:0]   resp_rdata,
   output logic [4:0]              resp_rd_addr,
   output logic                    misaligned,
   output logic                    bus_error
);

   typedef enum logic [1:0] {IDLE, ACCESS, RESP} state_t;

   localparam int unsigned CW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
   localparam logic [CW-1:0] CNT_LAST = (TIMEOUT_CYCLES == 0) ? '0 : CW'(TIMEOUT_CYCLES - 1);

   state_t state, state_nxt;

   logic [CW-1:0]         cnt;
   logic [1:0]            size_q;
   logic [1:0]            off_q;
   logic                  uns_q;
   logic [4:0]            rd_q;

   logic                  aligned;
   logic                  take;
   logic                  start;
   logic                  timeout_hit;
   logic [3:0]            strb;
   logic [DATA_WIDTH-1:0] wlanes;
   logic [DATA_WIDTH-1:0] sh;
   logic [DATA_WIDTH-1:0] ext;

   // Request qualification: any valid op is consumed in IDLE, only aligned ones reach memory
   always_comb begin
      aligned = 1'b1;
      if (req_size[1])
         aligned = (addr[1:0] == 2'b00);
      else if (req_size[0])
         aligned = ~addr[0];
      take        = (state == IDLE) && req_valid && (req_load || req_store);
      start       = take && aligned;
      timeout_hit = (TIMEOUT_CYCLES != 0) && (cnt == CNT_LAST);
   end

   always_comb begin
      strb   = 4'b1111;
      wlanes = wdata;
      case (req_size)
         2'b00: begin
            strb   = 4'b0001 << addr[1:0];
            wlanes = {4{wdata[7:0]}};
         end
         2'b01: begin
            strb   = 4'b0011 << addr[1:0];
            wlanes = {2{wdata[15:0]}};
         end
         default: ;
      endcase
   end

   always_comb begin
      sh  = mem_rdata >> {off_q, 3'b000};
      ext = mem_rdata;
      case (size_q)
         2'b00: ext = uns_q ? {{(DATA_WIDTH-8){1'b0}}, sh[7:0]}
                            : {{(DATA_WIDTH-8){sh[7]}}, sh[7:0]};
         2'b01: ext = uns_q ? {{(DATA_WIDTH-16){1'b0}}, sh[15:0]}
                            : {{(DATA_WIDTH-16){sh[15]}}, sh[15:0]};
         default: ;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)
         state <= IDLE;
      else
         state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      case (state)
         IDLE:    if (start) state_nxt = ACCESS;
         ACCESS: begin
            if (mem_ack)
               state_nxt = mem_we ? IDLE : RESP;
            else if (timeout_hit)
               state_nxt = IDLE;
         end
         RESP:    state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   always_comb begin
      req_ready  = (state == IDLE);
      mem_req    = (state == ACCESS);
      resp_valid = (state == RESP);
      stall      = req_valid && !req_ready;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt          <= '0;
         size_q       <= '0;
         off_q        <= '0;
         uns_q        <= 1'b0;
         rd_q         <= '0;
         mem_we       <= 1'b0;
         mem_addr     <= '0;
         mem_wstrb    <= '0;
         mem_wdata    <= '0;
         resp_rdata   <= '0;
         resp_rd_addr <= '0;
         misaligned   <= 1'b0;
         bus_error    <= 1'b0;
      end else begin
         misaligned <= take && !aligned;
         bus_error  <= (state == ACCESS) && !mem_ack && timeout_hit;
         if (start) begin
            cnt       <= '0;
            size_q    <= req_size;
            off_q     <= addr[1:0];
            uns_q     <= req_unsigned;
            rd_q      <= rd_addr;
            mem_we    <= req_store;
            mem_addr  <= {addr[31:2], 2'b00};
            mem_wstrb <= req_store ? strb : 4'b0000;
            mem_wdata <= req_store ? wlanes : '0;
         end
         if (state == ACCESS) begin
            cnt <= cnt + 1'b1;
            if (mem_ack && !mem_we) begin
               resp_rdata   <= ext;
               resp_rd_addr <= rd_q;
            end
         end
      end
   end

endmodule

// File: tb/tb_load_store_unit.sv
// Directed bench for load_store_unit: loads, stores, misalignment, timeout and async reset.
module tb_load_store_unit;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        req_valid, req_ready, req_load, req_store, req_unsigned;
   logic [1:0]  req_size;
   logic [31:0] addr, wdata;
   logic [4:0]  rd_addr;
   logic        stall, mem_req, mem_we, mem_ack;
   logic [31:0] mem_addr, mem_wdata, mem_rdata;
   logic [3:0]  mem_wstrb;
   logic        resp_valid, misaligned, bus_error;
   logic [31:0] resp_rdata;
   logic [4:0]  resp_rd_addr;

   int passed = 0;
   int total  = 0;

   always #5 clk = ~clk;

   load_store_unit #(.DATA_WIDTH(32), .TIMEOUT_CYCLES(4)) dut (
      .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_ready(req_ready),
      .req_load(req_load), .req_store(req_store), .req_size(req_size),
      .req_unsigned(req_unsigned), .addr(addr), .wdata(wdata), .rd_addr(rd_addr),
      .stall(stall), .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr),
      .mem_wstrb(mem_wstrb), .mem_wdata(mem_wdata), .mem_ack(mem_ack),
      .mem_rdata(mem_rdata), .resp_valid(resp_valid), .resp_rdata(resp_rdata),
      .resp_rd_addr(resp_rd_addr), .misaligned(misaligned), .bus_error(bus_error)
   );

   task automatic drive_req(input logic ld, input logic st, input logic [1:0] sz,
                            input logic un, input logic [31:0] a, input logic [31:0] wd,
                            input logic [4:0] rd);
      req_valid = 1'b1; req_load = ld; req_store = st; req_size = sz;
      req_unsigned = un; addr = a; wdata = wd; rd_addr = rd;
   endtask

   task automatic test_reset;
      rst_n = 1'b0; req_valid = 0; req_load = 0; req_store = 0; req_size = 0;
      req_unsigned = 0; addr = 0; wdata = 0; rd_addr = 0; mem_ack = 0; mem_rdata = 0;
      repeat (2) @(negedge clk);
      total++; if (req_ready !== 1'b1) $display("FAIL reset_ready got=%b exp=1", req_ready); else passed++;
      total++; if (mem_req !== 1'b0) $display("FAIL reset_mem_req got=%b exp=0", mem_req); else passed++;
      total++; if ({resp_valid, misaligned, bus_error, stall, mem_we} !== 5'b0)
         $display("FAIL reset_pulses got=%b exp=00000", {resp_valid, misaligned, bus_error, stall, mem_we}); else passed++;
      total++; if ({mem_wstrb, mem_addr, resp_rdata} !== 68'h0)
         $display("FAIL reset_regs got=%h exp=0", {mem_wstrb, mem_addr, resp_rdata}); else passed++;
      rst_n = 1'b1;
   endtask

   task automatic test_lbu;
      @(negedge clk) drive_req(1, 0, 2'b00, 1, 32'h103, 32'h0, 5'd7);
      @(negedge clk);
      total++; if (mem_req !== 1'b1) $display("FAIL lbu_mem_req got=%b exp=1", mem_req); else passed++;
      total++; if (mem_addr !== 32'h100) $display("FAIL lbu_mem_addr got=%h exp=00000100", mem_addr); else passed++;
      total++; if ({mem_we, mem_wstrb} !== 5'b0) $display("FAIL lbu_we_strb got=%b exp=00000", {mem_we, mem_wstrb}); else passed++;
      total++; if ({stall, req_ready} !== 2'b10) $display("FAIL lbu_stall got=%b exp=10", {stall, req_ready}); else passed++;
      req_valid = 0; addr = 32'hFFFF_FFFF; req_size = 2'b10;
      @(negedge clk);
      total++; if (mem_addr !== 32'h100) $display("FAIL lbu_addr_held got=%h exp=00000100", mem_addr); else passed++;
      mem_ack = 1; mem_rdata = 32'hAABBCCDD;
      @(negedge clk);
      mem_ack = 0; mem_rdata = 0;
      total++; if (resp_valid !== 1'b1) $display("FAIL lbu_resp_valid got=%b exp=1", resp_valid); else passed++;
      total++; if (resp_rdata !== 32'h000000AA) $display("FAIL lbu_rdata got=%h exp=000000aa", resp_rdata); else passed++;
      total++; if (resp_rd_addr !== 5'd7) $display("FAIL lbu_rd got=%0d exp=7", resp_rd_addr); else passed++;
      total++; if (mem_req !== 1'b0) $display("FAIL lbu_req_drop got=%b exp=0", mem_req); else passed++;
      @(negedge clk);
      total++; if ({resp_valid, req_ready} !== 2'b01) $display("FAIL lbu_pulse_end got=%b exp=01", {resp_valid, req_ready}); else passed++;
      total++; if (resp_rdata !== 32'h000000AA) $display("FAIL lbu_rdata_hold got=%h exp=000000aa", resp_rdata); else passed++;
   endtask

   task automatic test_lb_lhu;
      drive_req(1, 0, 2'b00, 0, 32'h102, 32'h0, 5'd3);
      @(negedge clk);
      req_valid = 0; mem_ack = 1; mem_rdata = 32'h00801234;
      @(negedge clk);
      mem_ack = 0;
      total++; if ({resp_valid, resp_rdata} !== {1'b1, 32'hFFFFFF80})
         $display("FAIL lb_sext got=%b/%h exp=1/ffffff80", resp_valid, resp_rdata); else passed++;
      @(negedge clk) drive_req(1, 0, 2'b01, 1, 32'h102, 32'h0, 5'd4);
      @(negedge clk);
      req_valid = 0; mem_ack = 1;
      @(negedge clk);
      mem_ack = 0;
      total++; if ({resp_valid, resp_rdata} !== {1'b1, 32'h00000080})
         $display("FAIL lhu_zext got=%b/%h exp=1/00000080", resp_valid, resp_rdata); else passed++;
      total++; if (resp_rd_addr !== 5'd4) $display("FAIL lhu_rd got=%0d exp=4", resp_rd_addr); else passed++;
      @(negedge clk);
   endtask

   task automatic test_back_to_back;
      drive_req(0, 1, 2'b00, 0, 32'h101, 32'h12345678, 5'd0);
      @(negedge clk);
      req_valid = 0;
      total++; if ({mem_req, mem_we, mem_wstrb} !== 6'b110010)
         $display("FAIL sb_strb got=%b exp=110010", {mem_req, mem_we, mem_wstrb}); else passed++;
      total++; if (mem_wdata !== 32'h78787878) $display("FAIL sb_wdata got=%h exp=78787878", mem_wdata); else passed++;
      mem_ack = 1;
      @(negedge clk);
      mem_ack = 0;
      total++; if ({resp_valid, req_ready} !== 2'b01) $display("FAIL sb_done got=%b exp=01", {resp_valid, req_ready}); else passed++;
      drive_req(0, 1, 2'b01, 0, 32'h102, 32'h0000BEEF, 5'd0);
      @(negedge clk);
      req_valid = 0;
      total++; if ({mem_req, mem_wstrb} !== 5'b11100) $display("FAIL sh_strb got=%b exp=11100", {mem_req, mem_wstrb}); else passed++;
      total++; if (mem_wdata !== 32'hBEEFBEEF) $display("FAIL sh_wdata got=%h exp=beefbeef", mem_wdata); else passed++;
      mem_ack = 1;
      @(negedge clk);
      mem_ack = 0;
      total++; if ({resp_valid, resp_rdata} !== {1'b0, 32'h00000080})
         $display("FAIL sh_no_resp got=%b/%h exp=0/00000080", resp_valid, resp_rdata); else passed++;
   endtask

   task automatic test_misaligned;
      @(negedge clk) drive_req(1, 0, 2'b10, 0, 32'h102, 32'h0, 5'd2);
      @(negedge clk);
      req_valid = 0;
      total++; if ({misaligned, mem_req, req_ready} !== 3'b101)
         $display("FAIL lw_misaligned got=%b exp=101", {misaligned, mem_req, req_ready}); else passed++;
      @(negedge clk);
      total++; if ({misaligned, mem_req} !== 2'b00) $display("FAIL misaligned_pulse got=%b exp=00", {misaligned, mem_req}); else passed++;
      drive_req(0, 0, 2'b10, 0, 32'h104, 32'h0, 5'd2);
      @(negedge clk);
      req_valid = 0;
      total++; if ({misaligned, mem_req, bus_error, req_ready} !== 4'b0001)
         $display("FAIL noop_drop got=%b exp=0001", {misaligned, mem_req, bus_error, req_ready}); else passed++;
   endtask

   task automatic test_timeout;
      @(negedge clk) drive_req(1, 0, 2'b10, 0, 32'h300, 32'h0, 5'd9);
      for (int i = 1; i <= 4; i++) begin
         @(negedge clk);
         req_valid = 0;
         total++; if ({mem_req, bus_error} !== 2'b10)
            $display("FAIL to_wait%0d got=%b exp=10", i, {mem_req, bus_error}); else passed++;
      end
      @(negedge clk);
      total++; if ({mem_req, bus_error, resp_valid} !== 3'b010)
         $display("FAIL to_expire got=%b exp=010", {mem_req, bus_error, resp_valid}); else passed++;
      @(negedge clk);
      total++; if ({bus_error, req_ready} !== 2'b01) $display("FAIL to_pulse got=%b exp=01", {bus_error, req_ready}); else passed++;
      drive_req(1, 0, 2'b10, 0, 32'h300, 32'h0, 5'd9);
      for (int i = 1; i <= 4; i++) begin
         @(negedge clk);
         req_valid = 0;
      end
      mem_ack = 1; mem_rdata = 32'hCAFEF00D;
      @(negedge clk);
      mem_ack = 0;
      total++; if ({resp_valid, bus_error} !== 2'b10) $display("FAIL to_late_ack got=%b exp=10", {resp_valid, bus_error}); else passed++;
      total++; if (resp_rdata !== 32'hCAFEF00D) $display("FAIL to_late_data got=%h exp=cafef00d", resp_rdata); else passed++;
      @(negedge clk);
   endtask

   task automatic test_async_reset;
      drive_req(1, 0, 2'b10, 0, 32'h400, 32'h0, 5'd1);
      @(negedge clk);
      req_valid = 0;
      total++; if (mem_req !== 1'b1) $display("FAIL ar_pre got=%b exp=1", mem_req); else passed++;
      #2 rst_n = 1'b0;
      #1;
      total++; if ({mem_req, req_ready} !== 2'b01) $display("FAIL ar_abort got=%b exp=01", {mem_req, req_ready}); else passed++;
      @(negedge clk) rst_n = 1'b1;
      @(negedge clk);
      total++; if ({resp_valid, mem_req} !== 2'b00) $display("FAIL ar_no_resp got=%b exp=00", {resp_valid, mem_req}); else passed++;
      drive_req(0, 1, 2'b10, 0, 32'h200, 32'h11223344, 5'd0);
      @(negedge clk);
      req_valid = 0;
      total++; if ({mem_req, mem_we, mem_wstrb} !== 6'b111111)
         $display("FAIL sw_strb got=%b exp=111111", {mem_req, mem_we, mem_wstrb}); else passed++;
      total++; if ({mem_addr, mem_wdata} !== {32'h200, 32'h11223344})
         $display("FAIL sw_addr_data got=%h/%h exp=00000200/11223344", mem_addr, mem_wdata); else passed++;
      mem_ack = 1;
      @(negedge clk);
      mem_ack = 0;
      total++; if ({resp_valid, req_ready, mem_req} !== 3'b010)
         $display("FAIL sw_done got=%b exp=010", {resp_valid, req_ready, mem_req}); else passed++;
   endtask

   initial begin
      test_reset;
      test_lbu;
      test_lb_lhu;
      test_back_to_back;
      test_misaligned;
      test_timeout;
      test_async_reset;
      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end

endmodule
